// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - sample, RAM, coefficient and output bundle for fir_tap_sequencer
interface fir_tap_sequencer_if;
   // input sample stream
   logic               x_avail;
   logic signed [17:0] x_real;
   logic signed [17:0] x_imag;

   // sample RAM write port
   logic [35:0]        ram_data;
   logic [7:0]         ram_wraddress;
   logic               ram_wren;

   // sample RAM read port
   logic [7:0]         ram_rdaddress;
   logic [35:0]        ram_q;

   // coefficient ROM
   logic [7:0]         coef_addr;
   logic signed [17:0] coef;

   // filtered output and status
   logic signed [23:0] y_real;
   logic signed [23:0] y_imag;
   logic               y_avail;
   logic               busy;
   logic               overrun;

   modport master (
      input  x_avail, x_real, x_imag, ram_q, coef,
      output ram_data, ram_wraddress, ram_wren, ram_rdaddress, coef_addr,
             y_real, y_imag, y_avail, busy, overrun
   );

   modport slave (
      output x_avail, x_real, x_imag, ram_q, coef,
      input  ram_data, ram_wraddress, ram_wren, ram_rdaddress, coef_addr,
             y_real, y_imag, y_avail, busy, overrun
   );
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - circular sample-history writer and decimating tap-sweep MAC controller
// Optional feature macro: FIR_SAT_EN (clamp y on accumulator overflow instead of wrapping)
module fir_tap_sequencer #(
   parameter int TAPS  = 256,
   parameter int DECIM = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   fir_tap_sequencer_if.master  bus
);

   localparam logic [7:0] K_LAST    = 8'(TAPS - 1);
   localparam logic [7:0] DCNT_LAST = 8'(DECIM - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // write side
   logic [7:0]         wptr;
   logic [7:0]         dcnt;
   logic [35:0]        wr_data;
   logic [7:0]         wr_addr;
   logic               wr_en;
   logic               trig;

   // sweep side
   logic [7:0]         rd_addr;
   logic [7:0]         k;
   logic               drain_cnt;
   logic               overrun;

   // decoded FSM controls
   logic               start_run;
   logic               drop_run;
   logic               tap_v;
   logic               tap_first;
   logic               load_y;
   logic               busy;
   logic               y_avail;

   // MAC pipeline
   logic               q_v;
   logic               q_first;
   logic               p_v;
   logic               p_first;
   logic signed [35:0] prod_r;
   logic signed [35:0] prod_i;
   logic signed [43:0] acc_r;
   logic signed [43:0] acc_i;
   logic signed [43:0] acc_r_nxt;
   logic signed [43:0] acc_i_nxt;
   logic signed [23:0] y_r;
   logic signed [23:0] y_i;
   logic signed [23:0] y_r_nxt;
   logic signed [23:0] y_i_nxt;
   logic               unused_acc;

   // Sample write path: register one RAM write per x_avail, advance the
   // circular write pointer and count toward the next decimated output.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         wr_data <= '0;
         wr_addr <= '0;
         wptr    <= '0;
         dcnt    <= '0;
         trig    <= 1'b0;
      end else begin
         wr_en <= bus.x_avail;
         trig  <= bus.x_avail && (dcnt == DCNT_LAST);
         if (bus.x_avail) begin
            wr_data <= {bus.x_real, bus.x_imag};
            wr_addr <= wptr;
            wptr    <= wptr + 8'd1;
            dcnt    <= (dcnt == DCNT_LAST) ? 8'd0 : dcnt + 8'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and decoded controls; a trigger seen in any non-idle
   // state (including the DONE cycle) is dropped rather than queued.
   always_comb begin
      state_nxt = state;
      start_run = 1'b0;
      drop_run  = 1'b0;
      tap_v     = 1'b0;
      tap_first = 1'b0;
      load_y    = 1'b0;
      busy      = 1'b1;
      y_avail   = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (trig) begin
               start_run = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            drop_run  = trig;
            tap_v     = 1'b1;
            tap_first = (k == 8'd0);
            if (k == K_LAST) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            drop_run = trig;
            if (drain_cnt) begin
               load_y    = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            drop_run  = trig;
            y_avail   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Tap sweep: newest sample first (base, base-1, ...) paired with k = 0, 1, ...
   // plus the two-cycle drain timer and the sticky overrun flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr   <= '0;
         k         <= '0;
         drain_cnt <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (start_run) begin
            rd_addr <= wr_addr;
            k       <= 8'd0;
         end else if (tap_v && (k != K_LAST)) begin
            rd_addr <= rd_addr - 8'd1;
            k       <= k + 8'd1;
         end
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         if (drop_run) begin
            overrun <= 1'b1;
         end
      end
   end

   // MAC stage 1: tag RAM/ROM read data one cycle after the address and
   // register the real-by-complex products.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_v     <= 1'b0;
         q_first <= 1'b0;
         p_v     <= 1'b0;
         p_first <= 1'b0;
         prod_r  <= '0;
         prod_i  <= '0;
      end else begin
         q_v     <= tap_v;
         q_first <= tap_first;
         p_v     <= q_v;
         p_first <= q_first;
         if (q_v) begin
            prod_r <= $signed(bus.ram_q[35:18]) * $signed(bus.coef);
            prod_i <= $signed(bus.ram_q[17:0]) * $signed(bus.coef);
         end
      end
   end

   // Accumulator next value: the first tap of a run reloads instead of adding.
   always_comb begin
      acc_r_nxt = {{8{prod_r[35]}}, prod_r};
      acc_i_nxt = {{8{prod_i[35]}}, prod_i};
      if (!p_first) begin
         acc_r_nxt = acc_r + {{8{prod_r[35]}}, prod_r};
         acc_i_nxt = acc_i + {{8{prod_i[35]}}, prod_i};
      end
   end

   // MAC stage 2: accumulate every valid product.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_r <= '0;
         acc_i <= '0;
      end else if (p_v) begin
         acc_r <= acc_r_nxt;
         acc_i <= acc_i_nxt;
      end
   end

   // Output slice taken from the final accumulate so y appears in the DONE cycle.
   always_comb begin
      y_r_nxt = acc_r_nxt[41:18];
      y_i_nxt = acc_i_nxt[41:18];
`ifdef FIR_SAT_EN
      if (acc_r_nxt[43:41] != {3{acc_r_nxt[43]}}) begin
         y_r_nxt = acc_r_nxt[43] ? 24'h800000 : 24'h7FFFFF;
      end
      if (acc_i_nxt[43:41] != {3{acc_i_nxt[43]}}) begin
         y_i_nxt = acc_i_nxt[43] ? 24'h800000 : 24'h7FFFFF;
      end
`else
      y_r_nxt = acc_r_nxt[41:18];
      y_i_nxt = acc_i_nxt[41:18];
`endif
   end

   assign unused_acc = ^{acc_r_nxt, acc_i_nxt};

   // Output registers: y holds until the next completed run.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         y_r <= '0;
         y_i <= '0;
      end else if (load_y) begin
         y_r <= y_r_nxt;
         y_i <= y_i_nxt;
      end
   end

   assign bus.ram_data      = wr_data;
   assign bus.ram_wraddress = wr_addr;
   assign bus.ram_wren      = wr_en;
   assign bus.ram_rdaddress = rd_addr;
   assign bus.coef_addr     = k;
   assign bus.y_real        = y_r;
   assign bus.y_imag        = y_i;
   assign bus.y_avail       = y_avail;
   assign bus.busy          = busy;
   assign bus.overrun       = overrun;

endmodule
